// File: rtl/arf_pkg.sv
// Shared encodings for the address register file sequencer: commands, file
// function/select codes, one-cold register enables and FSM states.
package arf_pkg;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'b000,
        CMD_FETCH = 3'b001,
        CMD_JUMP  = 3'b010,
        CMD_LDAR  = 3'b011,
        CMD_PUSH  = 3'b100,
        CMD_POP   = 3'b101,
        CMD_CALL  = 3'b110,
        CMD_RET   = 3'b111
    } cmd_e;

    localparam logic [2:0] FUN_DEC  = 3'b000;
    localparam logic [2:0] FUN_INC  = 3'b001;
    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_CLR  = 3'b011;

    localparam logic [1:0] SEL_PC = 2'b00;
    localparam logic [1:0] SEL_AR = 2'b10;
    localparam logic [1:0] SEL_SP = 2'b11;

    localparam logic [2:0] REG_NONE = 3'b111;
    localparam logic [2:0] REG_PC   = 3'b011;
    localparam logic [2:0] REG_AR   = 3'b101;
    localparam logic [2:0] REG_SP   = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EX1  = 2'b01,
        ST_EX2  = 2'b10,
        ST_EX3  = 2'b11
    } state_e;

    // Commands that grow the stack by one entry when they complete.
    function automatic logic is_grow(input cmd_e c);
        return (c == CMD_PUSH) || (c == CMD_CALL);
    endfunction

    // Commands that shrink the stack by one entry when they complete.
    function automatic logic is_shrink(input cmd_e c);
        return (c == CMD_POP) || (c == CMD_RET);
    endfunction

endpackage

// File: rtl/arf_sequencer.sv
// Multi-cycle Moore controller that sequences PC/AR/SP operations in the
// address register file and tracks stack depth for bound checking.
module arf_sequencer
    import arf_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CmdValid,
    input  logic [2:0] Cmd,
    output logic       CmdReady,
    output logic [1:0] OutCSel,
    output logic [1:0] OutDSel,
    output logic [2:0] FunSel,
    output logic [2:0] RegSel,
    output logic       AddrValid,
    output logic       MemWrite,
    output logic       Done,
    output logic       Err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_e        state_q, state_d;
    cmd_e          cmd_q, cmd_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          reject_s;

    // Bounds violation is judged in EX1; depth cannot change between acceptance and EX1.
    assign reject_s = (state_q == ST_EX1) &&
                      ((is_grow(cmd_q) && (depth_q == DEPTH_MAX)) ||
                       (is_shrink(cmd_q) && (depth_q == {DW{1'b0}})));

    // State, latched command and stack depth registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            depth_q <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            depth_q <= depth_d;
        end
    end

    // Next-state, command capture and depth update.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        depth_d = depth_q;
        case (state_q)
            ST_IDLE: begin
                if (CmdValid) begin
                    cmd_d   = cmd_e'(Cmd);
                    state_d = ST_EX1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EX1: begin
                if (reject_s) begin
                    state_d = ST_IDLE;
                end else if ((cmd_q == CMD_PUSH) || (cmd_q == CMD_CALL) || (cmd_q == CMD_RET)) begin
                    state_d = ST_EX2;
                end else begin
                    state_d = ST_IDLE;
                    if ((cmd_q == CMD_POP) && (depth_q != {DW{1'b0}})) begin
                        depth_d = depth_q - DW'(1);
                    end else begin
                        depth_d = depth_q;
                    end
                end
            end
            ST_EX2: begin
                if (cmd_q == CMD_CALL) begin
                    state_d = ST_EX3;
                end else begin
                    state_d = ST_IDLE;
                    if ((cmd_q == CMD_PUSH) && (depth_q != DEPTH_MAX)) begin
                        depth_d = depth_q + DW'(1);
                    end else if ((cmd_q == CMD_RET) && (depth_q != {DW{1'b0}})) begin
                        depth_d = depth_q - DW'(1);
                    end else begin
                        depth_d = depth_q;
                    end
                end
            end
            ST_EX3: begin
                state_d = ST_IDLE;
                if ((cmd_q == CMD_CALL) && (depth_q != DEPTH_MAX)) begin
                    depth_d = depth_q + DW'(1);
                end else begin
                    depth_d = depth_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from state and latched command only.
    always_comb begin
        CmdReady  = 1'b0;
        OutCSel   = SEL_PC;
        OutDSel   = SEL_PC;
        FunSel    = FUN_DEC;
        RegSel    = REG_NONE;
        AddrValid = 1'b0;
        MemWrite  = 1'b0;
        Done      = 1'b0;
        Err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                CmdReady = 1'b1;
            end
            ST_EX1: begin
                if (reject_s) begin
                    Err  = 1'b1;
                    Done = 1'b1;
                end else begin
                    case (cmd_q)
                        CMD_NOP: begin
                            Done = 1'b1;
                        end
                        CMD_FETCH: begin
                            OutDSel   = SEL_PC;
                            AddrValid = 1'b1;
                            FunSel    = FUN_INC;
                            RegSel    = REG_PC;
                            Done      = 1'b1;
                        end
                        CMD_JUMP: begin
                            FunSel = FUN_LOAD;
                            RegSel = REG_PC;
                            Done   = 1'b1;
                        end
                        CMD_LDAR: begin
                            FunSel = FUN_LOAD;
                            RegSel = REG_AR;
                            Done   = 1'b1;
                        end
                        CMD_PUSH, CMD_CALL: begin
                            FunSel = FUN_DEC;
                            RegSel = REG_SP;
                        end
                        CMD_POP, CMD_RET: begin
                            OutDSel   = SEL_SP;
                            AddrValid = 1'b1;
                            FunSel    = FUN_INC;
                            RegSel    = REG_SP;
                            Done      = (cmd_q == CMD_POP);
                        end
                        default: begin
                            Done = 1'b1;
                        end
                    endcase
                end
            end
            ST_EX2: begin
                case (cmd_q)
                    CMD_PUSH: begin
                        OutDSel   = SEL_SP;
                        AddrValid = 1'b1;
                        MemWrite  = 1'b1;
                        Done      = 1'b1;
                    end
                    CMD_CALL: begin
                        OutCSel   = SEL_PC;
                        OutDSel   = SEL_SP;
                        AddrValid = 1'b1;
                        MemWrite  = 1'b1;
                    end
                    CMD_RET: begin
                        FunSel = FUN_LOAD;
                        RegSel = REG_PC;
                        Done   = 1'b1;
                    end
                    default: begin
                        Done = 1'b0;
                    end
                endcase
            end
            ST_EX3: begin
                if (cmd_q == CMD_CALL) begin
                    FunSel = FUN_LOAD;
                    RegSel = REG_PC;
                    Done   = 1'b1;
                end else begin
                    Done = 1'b0;
                end
            end
            default: begin
                CmdReady = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/arf_sequencer.md
# arf_sequencer

Multi-cycle controller for the address register file (PC, AR, SP). It accepts one command at a time over a valid/ready handshake and drives the file's `OutCSel`, `OutDSel`, `FunSel` and `RegSel` lines to sequence fetch, jump, AR load, push, pop, call and return. It also flags the memory address phase and tracks stack depth for overflow and underflow. It sits between the instruction control unit and the address register file.

## Interface
- `DEPTH`, default 256: maximum stack entries; the depth counter is `$clog2(DEPTH+1)` bits.
- `Clock` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high.
- `CmdValid` in 1: command request.
- `Cmd` in 3: 000 NOP, 001 FETCH, 010 JUMP, 011 LDAR, 100 PUSH, 101 POP, 110 CALL, 111 RET.
- `CmdReady` out 1: high only in IDLE.
- `OutCSel` out 2: to the file; 00 selects PC, 10 AR, 11 SP.
- `OutDSel` out 2: to the file; same encoding as `OutCSel`.
- `FunSel` out 3: to the file; 000 decrement, 001 increment, 010 load `I`, 011 clear.
- `RegSel` out 3: to the file; active-low enables, bit 2 PC, bit 1 AR, bit 0 SP.
- `AddrValid` out 1: OutD carries a memory address this cycle.
- `MemWrite` out 1: the address phase is a write; OutC carries the write data.
- `Done` out 1: one-cycle pulse in the last execute cycle.
- `Err` out 1: one-cycle pulse when a command is rejected for stack bounds.

## Operation
- FSM states: IDLE, EX1, EX2, EX3.
  - The command is latched on `CmdValid && CmdReady`, and the FSM moves IDLE→EX1.
  - All `ARF` outputs are decoded from state and the latched command (Moore). No output depends combinationally on `Cmd`.
- FETCH (EX1): OutDSel=00, AddrValid=1, FunSel=001, RegSel=011. The PC value is presented, then PC is post-incremented at the edge.
- JUMP (EX1): FunSel=010, RegSel=011.
- LDAR (EX1): FunSel=010, RegSel=101.
- NOP (EX1): RegSel=111 and Done.
- PUSH:
  - EX1: FunSel=000, RegSel=110.
  - EX2: OutDSel=11, AddrValid=1, MemWrite=1, RegSel=111.
  - Depth +1 at the end of EX2.
- POP (EX1): OutDSel=11, AddrValid=1, FunSel=001, RegSel=110. Depth −1.
- CALL:
  - EX1: SP decrement.
  - EX2: OutDSel=11, OutCSel=00, AddrValid=1, MemWrite=1.
  - EX3: PC load (FunSel=010, RegSel=011). Depth +1.
- RET:
  - EX1: as POP.
  - EX2: PC load from `I`, which is the returned memory data. Depth −1.
- Bounds:
  - PUSH or CALL accepted with depth==DEPTH, or POP or RET accepted with depth==0: EX1 drives RegSel=111.
  - In that case Err=1 and Done=1 in EX1, the FSM returns to IDLE, and depth is unchanged.
- Every cycle where no register is named: RegSel=111, and OutCSel, OutDSel and FunSel are 00, 00 and 000.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State IDLE, depth 0.
  - CmdReady=1, RegSel=111, FunSel=000, OutCSel=00, OutDSel=00.
  - AddrValid=0, MemWrite=0, Done=0, Err=0.
- Latency and throughput:
  - Acceptance at edge k puts EX1 in cycle k+1.
  - 1-cycle commands (FETCH, JUMP, LDAR, NOP, POP, rejected ops) pulse Done in k+1, and CmdReady is high again in k+2.
  - PUSH and RET complete in 2 execute cycles, CALL in 3.
  - Maximum throughput is one 1-cycle command per 2 cycles.
- `Cmd` is sampled only at acceptance. Changes to `Cmd` or `CmdValid` while busy are ignored. A request held over Done is accepted at the first IDLE edge.
- Register updates in the file occur at the edge ending the cycle where the enable is asserted.
- Depth changes at that same edge.
- Depth never wraps.
- Reset mid-command aborts the command. No Done is issued, and partial SP changes in the file are not undone.

## Structure
- Shared package `arf_pkg` holds:
  - command encodings;
  - FunSel constants (DEC, INC, LOAD, CLR);
  - select codes (SEL_PC=2'b00, SEL_AR=2'b10, SEL_SP=2'b11);
  - RegSel one-cold constants;
  - the state enum.
- No sub-module needed. The depth counter stays inline.

## Test plan
- Reset asserted mid-CALL in EX2 → all outputs at reset values within the same cycle, then CmdReady=1 and depth=0.
- FETCH with PC=0x0010 → EX1: OutDSel=00, AddrValid=1, FunSel=001, RegSel=011; PC=0x0011 afterwards; Done at k+1.
- PUSH from SP=0x00FF → EX1 decrements SP to 0x00FE; EX2 shows OutD=0x00FE with MemWrite=1; depth=1.
- CALL with PC=0x0040, I=0x0200 → EX2: OutC=0x0040 and OutD=SP−1, MemWrite=1; EX3 loads PC=0x0200; Done only in EX3.
- POP at depth 0 → Err=1 and Done=1 in EX1, RegSel=111, SP unchanged; 256 PUSHes then a 257th → Err on the 257th.
- Back-to-back: CmdValid held with FETCH, JUMP → accepted on alternate edges; Cmd changed during EX1 → executed command unaffected.
